// File: rtl/sys_mem_arb_pkg.sv
// Shared types and helpers for the system-memory arbiter: agent-ID width,
// arbiter state encoding and the round-robin pick.
package sys_mem_arb_pkg;

    localparam int MAX_AGENTS = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] id;
    } rr_pick_t;

    function automatic int agent_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester at or after 'start', wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_AGENTS-1:0] req,
                                         input int start, input int n);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < MAX_AGENTS; k++) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !res.found && req[idx[2:0]]) begin
                res.found = 1'b1;
                res.id    = idx[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sys_mem_rd_tag_fifo.sv
// Synchronous FIFO holding the agent ID of every read still awaiting data.
// A push is refused while full, even when a pop happens in the same cycle.
module sys_mem_rd_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sys_mem_arb.sv
// Round-robin arbiter between NUM_AGENTS initiators and one system-memory port,
// with read-data routing by agent tag. Define SYS_MEM_ARB_BURST_LOCK_EN to hold
// the grant for up to MAX_BURST_LEN accepts.
module sys_mem_arb
    import sys_mem_arb_pkg::*;
#(
    parameter int NUM_AGENTS         = 2,
    parameter int SYS_MEM_DATA_W     = 32,
    parameter int SYS_MEM_ADDR_W     = 27,
    parameter int MAX_RD_OUTSTANDING = 8,
    parameter int MAX_BURST_LEN      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [NUM_AGENTS-1:0]     agent_mem_wait,
    input  logic [NUM_AGENTS-1:0]     agent_mem_wren,
    input  logic [NUM_AGENTS-1:0]     agent_mem_rden,
    input  logic [SYS_MEM_ADDR_W-1:0] agent_mem_addr  [NUM_AGENTS],
    input  logic [SYS_MEM_DATA_W-1:0] agent_mem_wdata [NUM_AGENTS],
    output logic [NUM_AGENTS-1:0]     agent_mem_rd_valid,
    output logic [SYS_MEM_DATA_W-1:0] agent_mem_rdata [NUM_AGENTS],
    input  logic                      mem_wait,
    output logic                      mem_wren,
    output logic                      mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0] mem_addr,
    output logic [SYS_MEM_DATA_W-1:0] mem_wdata,
    input  logic                      mem_rd_valid,
    input  logic [SYS_MEM_DATA_W-1:0] mem_rdata,
    output logic                      err_unexp_rd
);

    localparam int ID_W     = agent_id_w(NUM_AGENTS);
    localparam int RD_CNT_W = $clog2(MAX_RD_OUTSTANDING) + 1;
`ifdef SYS_MEM_ARB_BURST_LOCK_EN
    localparam bit BURST_LOCK = 1'b1;
`else
    localparam bit BURST_LOCK = 1'b0;
`endif
    // A lock length of 1 degenerates to re-arbitration on every accept.
    localparam int LOCK_LEN = BURST_LOCK ? MAX_BURST_LEN : 1;
    localparam int BCNT_W   = $clog2(LOCK_LEN + 1);

    arb_state_e          state, state_nxt;
    logic [ID_W-1:0]     gnt_id, gnt_id_nxt;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]     ptr_after;
    logic [BCNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [NUM_AGENTS-1:0] req_vec;
    logic [NUM_AGENTS-1:0] own_mask;
    rr_pick_t            pick;

    logic                g_wr, g_rd, g_req;
    logic                rd_blocked;
    logic                accept;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ID_W-1:0]     fifo_id;
    logic [RD_CNT_W-1:0] fifo_count;

    logic [NUM_AGENTS-1:0]     rd_valid_q;
    logic [SYS_MEM_DATA_W-1:0] rdata_q [NUM_AGENTS];

    assign req_vec = agent_mem_wren | agent_mem_rden;

    always_comb begin
        g_wr = 1'b0;
        g_rd = 1'b0;
        if (state == ST_GRANTED) begin
            g_wr = agent_mem_wren[gnt_id];
            g_rd = agent_mem_rden[gnt_id] & ~agent_mem_wren[gnt_id];
        end
    end

    assign g_req      = g_wr | g_rd;
    assign rd_blocked = g_rd && (fifo_count == RD_CNT_W'(MAX_RD_OUTSTANDING));
    assign mem_wren   = g_wr;
    assign mem_rden   = g_rd & ~rd_blocked;
    assign mem_addr   = (state == ST_GRANTED) ? agent_mem_addr[gnt_id]  : '0;
    assign mem_wdata  = (state == ST_GRANTED) ? agent_mem_wdata[gnt_id] : '0;
    assign accept     = (mem_wren | mem_rden) & ~mem_wait;

    always_comb begin
        agent_mem_wait = '1;
        if (state == ST_GRANTED) agent_mem_wait[gnt_id] = mem_wait | rd_blocked;
    end

    always_comb begin
        state_nxt     = state;
        gnt_id_nxt    = gnt_id;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        pick          = '0;
        own_mask      = '0;
        own_mask[gnt_id] = 1'b1;
        ptr_after     = (int'(gnt_id) == NUM_AGENTS - 1) ? '0 : gnt_id + 1'b1;
        case (state)
            ST_IDLE: begin
                burst_cnt_nxt = '0;
                pick = rr_pick(MAX_AGENTS'(req_vec), int'(rr_ptr), NUM_AGENTS);
                if (pick.found) begin
                    state_nxt  = ST_GRANTED;
                    gnt_id_nxt = ID_W'(pick.id);
                end
            end
            ST_GRANTED: begin
                if (accept) begin
                    if (burst_cnt != BCNT_W'(LOCK_LEN - 1)) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end else begin
                        burst_cnt_nxt = '0;
                        rr_ptr_nxt    = ptr_after;
                        pick = rr_pick(MAX_AGENTS'(req_vec & ~own_mask),
                                       int'(ptr_after), NUM_AGENTS);
                        if (pick.found) gnt_id_nxt = ID_W'(pick.id);
                        else            state_nxt  = ST_IDLE;
                    end
                end else if (!g_req) begin
                    // Request withdrawn before acceptance: release without access.
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt_id    <= gnt_id_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    assign fifo_push = accept & mem_rden & ~fifo_full;
    assign fifo_pop  = mem_rd_valid & ~fifo_empty;

    sys_mem_rd_tag_fifo #(
        .DEPTH (MAX_RD_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_rd_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (gnt_id),
        .pop       (fifo_pop),
        .pop_data  (fifo_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read return stage: routed one cycle after mem_rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q   <= '0;
            rdata_q      <= '{default: '0};
            err_unexp_rd <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            if (fifo_pop) begin
                rd_valid_q[fifo_id] <= 1'b1;
                rdata_q[fifo_id]    <= mem_rdata;
            end
            if (mem_rd_valid && fifo_empty) err_unexp_rd <= 1'b1;
        end
    end

    assign agent_mem_rd_valid = rd_valid_q;
    assign agent_mem_rdata    = rdata_q;

endmodule
